// File: rtl/gpu_mem_slave_pkg.sv
// Shared types for the GPU memory slave: Avalon byte request/response bundles and write FSM states.
package gpu_mem_slave_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [7:0]  writedata;
    logic        read;
    logic        write;
  } avalon_byte_req;

  typedef struct packed {
    logic [7:0] readdata;
    logic       waitrequest;
    logic       readdatavalid;
  } avalon_byte_rsp;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_STALL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/gpu_mem_slave_if.sv
// Avalon-MM byte-wide bus between the GPU controller (master) and the memory slave.
interface gpu_mem_slave_if;
    logic [31:0] s_address;
    logic [7:0]  s_writedata;
    logic        s_write;
    logic        s_read;
    logic        s_waitrequest;
    logic [7:0]  s_readdata;
    logic        s_readdatavalid;

    modport master (
        output s_address, s_writedata, s_write, s_read,
        input  s_waitrequest, s_readdata, s_readdatavalid
    );

    modport slave (
        input  s_address, s_writedata, s_write, s_read,
        output s_waitrequest, s_readdata, s_readdatavalid
    );
endinterface

// File: rtl/gpu_mem_slave_read_pipe.sv
// Fixed-latency return pipe for accepted reads; the last stage drives the Avalon read response.
module gpu_mem_slave_read_pipe #(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       tail_valid
);
    logic [READ_LATENCY-1:0] valid_q;
    logic [7:0]              data_q [READ_LATENCY];

    // Data stages only load behind a valid, so the output byte holds between returns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[READ_LATENCY-1];
    assign out_data   = data_q[READ_LATENCY-1];
    assign tail_valid = valid_q[READ_LATENCY-1];
endmodule

// File: rtl/gpu_mem_slave.sv
// Avalon-MM byte slave over on-chip RAM: pipelined reads, write wait-states, scan-out port.
module gpu_mem_slave
    import gpu_mem_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_PENDING  = 1,
    parameter int unsigned WRITE_WAIT   = 1,
    parameter int unsigned IDX_BITS     = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    gpu_mem_slave_if.slave      bus,
    input  logic [IDX_BITS-1:0] scan_addr,
    output logic [7:0]          scan_data,
    output logic [15:0]         oob_count
);
    localparam int unsigned PendW = $clog2(MAX_PENDING + 1);
    localparam int unsigned CntW  = (WRITE_WAIT == 0) ? 1 : $clog2(WRITE_WAIT + 1);

    avalon_byte_req req;
    avalon_byte_rsp rsp;

    assign req = '{address:   bus.s_address,
                   writedata: bus.s_writedata,
                   read:      bus.s_read,
                   write:     bus.s_write};

    logic [31:0]         offset;
    logic                in_window;
    logic [IDX_BITS-1:0] idx;

    assign offset    = req.address - ADDR_BASE;
    assign in_window = (req.address >= ADDR_BASE) && (offset < 32'(DEPTH));
    assign idx       = offset[IDX_BITS-1:0];

    wr_state_e       wr_state_q;
    logic [CntW-1:0] wcnt_q;
    logic            wr_wait;
    logic            wr_commit;

    always_comb begin
        wr_wait = 1'b0;
        if (req.write) begin
            if (wr_state_q == W_IDLE) wr_wait = (WRITE_WAIT != 0);
            else                      wr_wait = (wcnt_q < CntW'(WRITE_WAIT));
        end
    end

    assign wr_commit = req.write && !wr_wait && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wcnt_q     <= '0;
        end else begin
            unique case (wr_state_q)
                W_IDLE: begin
                    if (req.write && wr_wait) begin
                        wr_state_q <= W_STALL;
                        wcnt_q     <= CntW'(1);
                    end
                end
                W_STALL: begin
                    // Dropping the write abandons it; the next write waits the full count again.
                    if (!req.write || !wr_wait) wr_state_q <= W_IDLE;
                    else                        wcnt_q     <= wcnt_q + 1'b1;
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    logic             tail_valid;
    logic             rd_full;
    logic             rd_accept;
    logic             wait_req;
    logic [PendW-1:0] pending_q;
    logic [7:0]       rd_byte;
    logic [7:0]       pipe_data;
    logic             pipe_valid;

    // A retiring return frees its slot in the same cycle, so a full pipe keeps streaming.
    assign rd_full   = (pending_q == PendW'(MAX_PENDING)) && !tail_valid;
    assign wait_req  = reset || wr_wait || (req.read && (req.write || rd_full));
    assign rd_accept = req.read && !req.write && !wait_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else if (rd_accept && !tail_valid) begin
            pending_q <= pending_q + 1'b1;
        end else if (!rd_accept && tail_valid) begin
            pending_q <= pending_q - 1'b1;
        end
    end

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_commit && in_window) mem[idx] <= req.writedata;
    end

    assign rd_byte = in_window ? mem[idx] : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) scan_data <= '0;
        else       scan_data <= mem[scan_addr];
    end

    logic oob_hit;
    assign oob_hit = (rd_accept || wr_commit) && !in_window;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oob_count <= '0;
        end else if (oob_hit && (oob_count != 16'hFFFF)) begin
            oob_count <= oob_count + 1'b1;
        end
    end

    gpu_mem_slave_read_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_read_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_accept),
        .in_data   (rd_byte),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .tail_valid(tail_valid)
    );

    assign rsp = '{readdata: pipe_data, waitrequest: wait_req, readdatavalid: pipe_valid};

    assign bus.s_readdata      = rsp.readdata;
    assign bus.s_waitrequest   = rsp.waitrequest;
    assign bus.s_readdatavalid = rsp.readdatavalid;
endmodule

// File: tb/tb_gpu_mem_slave.sv
// Bench for gpu_mem_slave: directed and random traffic checked against a cycle-level reference model.
module tb_gpu_mem_slave;
    import gpu_mem_slave_pkg::*;

    localparam logic [31:0] Base    = 32'h0000_1000;
    localparam int          Lat     = 2;
    localparam int          MaxPend = 1;
    localparam int          WWait   = 2;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    always #5 clock = ~clock;

    gpu_mem_slave_if bus ();
    gpu_mem_slave_if bus2 ();
    logic [11:0] scan_addr;
    logic [7:0]  scan_data;
    logic [15:0] oob_count;
    logic [3:0]  scan_addr2;
    logic [7:0]  scan_data2;
    logic [15:0] oob_count2;

    gpu_mem_slave #(
        .ADDR_BASE(Base), .DEPTH(4096), .READ_LATENCY(Lat), .MAX_PENDING(MaxPend),
        .WRITE_WAIT(WWait)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .scan_addr(scan_addr),
        .scan_data(scan_data), .oob_count(oob_count)
    );

    // Zero-wait instance used to drive oob_count into saturation quickly.
    gpu_mem_slave #(
        .ADDR_BASE(Base), .DEPTH(16), .READ_LATENCY(2), .MAX_PENDING(1), .WRITE_WAIT(0)
    ) dut_sat (
        .clock(clock), .reset(reset2), .bus(bus2), .scan_addr(scan_addr2),
        .scan_data(scan_data2), .oob_count(oob_count2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte array, queue of outstanding returns, write-hold phase counter.
    typedef struct {
        int         due;
        logic [7:0] data;
        bit         known;
    } ret_t;

    ret_t       rq[$];
    logic [7:0] m_mem   [4096];
    bit         m_known [4096];
    int         cyc = 0;
    int         wr_phase = 0;
    int         m_oob = 0;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] m_scan = 8'h00;
    bit         m_rdata_known = 1'b1;
    bit         m_scan_known = 1'b1;
    bit         last_acc, last_commit, last_wait;
    int         ret_cyc[$];
    logic [7:0] ret_data[$];
    bit         ret_wait[$];
    bit         sat_done = 1'b0;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= Base) && ((a - Base) < 32'd4096);
    endfunction

    task automatic tick();
        bit         due, ww, exp_wait, acc, commit, iw;
        logic [11:0] ix;
        ret_t       r;
        @(negedge clock);
        if (reset) begin
            rq.delete();
            m_oob = 0; m_rdata = 8'h00; m_rdata_known = 1'b1;
            m_scan = 8'h00; m_scan_known = 1'b1; wr_phase = 0;
        end
        due = !reset && (rq.size() > 0) && (rq[0].due == cyc);
        ww  = bus.s_write && (wr_phase < WWait);
        if (reset)            exp_wait = 1'b1;
        else if (bus.s_write) exp_wait = ww || bus.s_read;
        else                  exp_wait = bus.s_read && (rq.size() >= MaxPend) && !due;
        chk("waitrequest", 32'(bus.s_waitrequest), 32'(exp_wait));
        chk("readdatavalid", 32'(bus.s_readdatavalid), 32'(due));
        if (due) begin
            m_rdata = rq[0].data;
            m_rdata_known = rq[0].known;
            void'(rq.pop_front());
            ret_cyc.push_back(cyc);
            ret_data.push_back(bus.s_readdata);
            ret_wait.push_back(bus.s_waitrequest);
        end
        if (m_rdata_known) chk("readdata", 32'(bus.s_readdata), 32'(m_rdata));
        chk("oob_count", 32'(oob_count), 32'(m_oob));
        if (m_scan_known) chk("scan_data", 32'(scan_data), 32'(m_scan));
        last_wait = bus.s_waitrequest;
        acc = 1'b0;
        commit = 1'b0;
        if (!reset) begin
            iw = in_win(bus.s_address);
            ix = 12'(bus.s_address - Base);
            acc = bus.s_read && !bus.s_write && !exp_wait;
            commit = bus.s_write && !ww;
            m_scan = m_mem[scan_addr];
            m_scan_known = m_known[scan_addr];
            if (acc) begin
                r.due = cyc + Lat;
                r.data = iw ? m_mem[ix] : 8'h00;
                r.known = iw ? m_known[ix] : 1'b1;
                rq.push_back(r);
                if (!iw && m_oob < 65535) m_oob++;
            end
            if (commit) begin
                if (iw) begin
                    m_mem[ix] = bus.s_writedata;
                    m_known[ix] = 1'b1;
                end else if (m_oob < 65535) begin
                    m_oob++;
                end
                wr_phase = 0;
            end else if (bus.s_write) begin
                wr_phase++;
            end else begin
                wr_phase = 0;
            end
        end
        last_acc = acc;
        last_commit = commit;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        bus.s_address = a; bus.s_writedata = d; bus.s_write = 1'b1; bus.s_read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_commit) break;
        end
        bus.s_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int n);
        bus.s_address = a; bus.s_read = 1'b1; bus.s_write = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (last_acc) break;
        end
        bus.s_read = 1'b0;
    endtask

    task automatic clear_rets();
        ret_cyc.delete(); ret_data.delete(); ret_wait.delete();
    endtask

    initial begin
        int         n, acc_cyc, base_cnt;
        bit         w0, w1, w2, saw_acc;
        logic [31:0] ra;
        bus.s_address = '0; bus.s_writedata = '0; bus.s_read = 1'b0; bus.s_write = 1'b0;
        bus2.s_address = '0; bus2.s_writedata = '0; bus2.s_read = 1'b0; bus2.s_write = 1'b0;
        scan_addr = '0; scan_addr2 = '0;
        for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;

        fork
            begin
                bus2.s_address = 32'h0000_0000; bus2.s_writedata = 8'h11; bus2.s_write = 1'b1;
                @(posedge clock); #1; @(posedge clock); #1;
                reset2 = 1'b0;
                repeat (65534) @(posedge clock);
                @(negedge clock); chk("sat_fffe", 32'(oob_count2), 32'hFFFE);
                @(negedge clock); chk("sat_ffff", 32'(oob_count2), 32'hFFFF);
                repeat (4) @(negedge clock);
                chk("sat_hold", 32'(oob_count2), 32'hFFFF);
                @(posedge clock); #1; bus2.s_write = 1'b0; bus2.s_read = 1'b1;
                @(posedge clock); #1; bus2.s_read = 1'b0;
                repeat (4) @(negedge clock);
                chk("sat_after_read", 32'(oob_count2), 32'hFFFF);
                sat_done = 1'b1;
            end
        join_none

        // Reset: outputs idle, waitrequest held high.
        repeat (3) tick();
        chk("rst_wait", 32'(bus.s_waitrequest), 32'd1);
        reset = 1'b0;
        tick();
        chk("post_rst_wait", 32'(last_wait), 32'd0);

        for (int i = 0; i < 64; i++) do_write(Base + 32'(i), 8'($urandom));
        do_write(Base + 32'h10, 8'hA5);
        for (int i = 0; i < 4; i++) do_write(Base + 32'(i), 8'(i + 1));

        // Single read with fixed latency.
        clear_rets();
        do_read(Base + 32'h10, n);
        acc_cyc = cyc - 1;
        repeat (4) tick();
        chk("single_count", 32'(ret_cyc.size()), 32'd1);
        if (ret_cyc.size() > 0) begin
            chk("single_latency", 32'(ret_cyc[0] - acc_cyc), 32'(Lat));
            chk("single_data", 32'(ret_data[0]), 32'hA5);
        end
        do_read(Base + 32'h10, n);
        chk("pending_drained", 32'(n), 32'd1);
        repeat (3) tick();

        // Held read stream, address stepping on each acceptance.
        clear_rets();
        bus.s_address = Base; bus.s_read = 1'b1; n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            tick();
            if (last_acc) begin
                n++;
                bus.s_address = Base + 32'(n);
            end
        end
        bus.s_read = 1'b0;
        repeat (4) tick();
        chk("stream_count", 32'(ret_data.size()), 32'd4);
        for (int k = 0; k < ret_data.size() && k < 4; k++) begin
            chk("stream_data", 32'(ret_data[k]), 32'(k + 1));
            chk("stream_wait_low", 32'(ret_wait[k]), 32'd0);
            if (k > 0) chk("stream_spacing", 32'(ret_cyc[k] - ret_cyc[k-1]), 32'd2);
        end

        // Write wait-states.
        bus.s_address = Base + 32'h20; bus.s_writedata = 8'h3C; bus.s_write = 1'b1;
        tick(); w0 = last_wait;
        tick(); w1 = last_wait;
        tick(); w2 = last_wait;
        chk("ww_commit", 32'(last_commit), 32'd1);
        bus.s_write = 1'b0;
        chk("ww_seq", {29'd0, w0, w1, w2}, 32'b110);
        clear_rets();
        do_read(Base + 32'h20, n);
        repeat (3) tick();
        if (ret_data.size() > 0) chk("ww_readback", 32'(ret_data[0]), 32'h3C);
        else chk("ww_readback_count", 32'(ret_data.size()), 32'd1);

        // Out-of-window read and write.
        clear_rets();
        do_read(32'h0000_0FFF, n);
        do_write(32'h0000_2000, 8'h5A);
        repeat (3) tick();
        chk("oob_two", 32'(oob_count), 32'd2);
        do_read(Base, n);
        repeat (3) tick();
        chk("oob_rets", 32'(ret_data.size()), 32'd2);
        if (ret_data.size() == 2) begin
            chk("oob_read_zero", 32'(ret_data[0]), 32'h00);
            chk("oob_ram_kept", 32'(ret_data[1]), 32'h01);
        end

        // Abandoned write, then a fresh write waits the full count again.
        bus.s_address = Base; bus.s_writedata = 8'hEE; bus.s_write = 1'b1;
        tick();
        bus.s_write = 1'b0;
        tick();
        chk("abandon_idle", 32'(dut.wr_state_q), 32'(W_IDLE));
        bus.s_address = Base + 32'h1; bus.s_writedata = 8'h99; bus.s_write = 1'b1;
        tick(); w0 = last_wait;
        tick(); w1 = last_wait;
        tick(); w2 = last_wait;
        bus.s_write = 1'b0;
        chk("restart_seq", {29'd0, w0, w1, w2}, 32'b110);
        clear_rets();
        do_read(Base, n);
        repeat (3) tick();
        if (ret_data.size() > 0) chk("abandon_nocommit", 32'(ret_data[0]), 32'h01);

        // Read and write together: write is served, read is stalled throughout.
        clear_rets();
        bus.s_address = Base + 32'h2; bus.s_writedata = 8'h77;
        bus.s_write = 1'b1; bus.s_read = 1'b1; saw_acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("both_wait", 32'(last_wait), 32'd1);
            saw_acc |= last_acc;
            if (last_commit) break;
        end
        chk("both_committed", 32'(last_commit), 32'd1);
        bus.s_write = 1'b0; bus.s_read = 1'b0;
        chk("both_no_accept", 32'(saw_acc), 32'd0);
        do_read(Base + 32'h2, n);
        repeat (3) tick();
        chk("both_rets", 32'(ret_data.size()), 32'd1);
        if (ret_data.size() > 0) chk("both_readback", 32'(ret_data[0]), 32'h77);

        // Scan port read of the earlier write.
        scan_addr = 12'h020;
        tick();
        chk("scan_3c", 32'(scan_data), 32'h3C);

        // Random traffic; writes avoid 0x20 region and stay within known bytes.
        for (int i = 0; i < 400; i++) begin
            if (i == 0 || last_acc || last_commit || $urandom_range(0, 3) == 0) begin
                n = $urandom_range(0, 9);
                bus.s_read  = (n <= 3) || (n == 6);
                bus.s_write = (n == 4) || (n == 5) || (n == 6);
                if (bus.s_write) ra = Base + 32'h30 + 32'($urandom_range(0, 15));
                else             ra = Base + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) ra = 32'h0000_2000 + 32'($urandom_range(0, 255));
                bus.s_address = ra;
                bus.s_writedata = 8'($urandom);
            end
            scan_addr = 12'($urandom_range(0, 63));
            tick();
        end
        bus.s_read = 1'b0; bus.s_write = 1'b0;
        repeat (4) tick();

        // Reset one cycle after an acceptance: the read never returns.
        do_read(Base + 32'h5, n);
        base_cnt = ret_cyc.size();
        reset = 1'b1;
        tick();
        chk("midrst_wait", 32'(last_wait), 32'd1);
        reset = 1'b0;
        repeat (6) tick();
        chk("midrst_no_return", 32'(ret_cyc.size()), 32'(base_cnt));
        scan_addr = 12'h020;
        tick();
        chk("scan_after_rst", 32'(scan_data), 32'h3C);

        for (int i = 0; i < 80000 && !sat_done; i++) @(posedge clock);
        chk("sat_done", 32'(sat_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
